// File: rtl/rr_sel_encoder_pkg.sv
// Shared types and constants for the round-robin select encoder.
package rr_sel_encoder_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_sel_encoder_pick8.sv
// Rotate-priority encoder: first set request scanning last+1, last+2, ... mod N_REQ.
module rr_pick8
    import rr_sel_encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        found_c = 1'b0;
        idx_c   = '0;
        // Offset N_REQ wraps back onto last itself, so it scans with lowest priority.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = last + IDX_W'(i);
            if (!found_c && req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_sel_encoder.sv
// Round-robin arbiter producing registered Sel/En for the 3-to-8 decoder,
// with bounded dwell and a one-cycle enable-low gap between grants.
module rr_sel_encoder
    import rr_sel_encoder_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Req,
    input  logic       Release,
    output logic [2:0] Sel,
    output logic       En,
    output logic       Busy
);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   last, last_n;
    logic [IDX_W-1:0]   sel_n;
    logic               en_n, busy_n;
    logic               found_c;
    logic [IDX_W-1:0]   idx_c;

    rr_pick8 u_pick (
        .req     (Req),
        .last    (last),
        .found_c (found_c),
        .idx_c   (idx_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= '1;
            Sel   <= '0;
            En    <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            last  <= last_n;
            Sel   <= sel_n;
            En    <= en_n;
            Busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        sel_n   = Sel;
        unique case (state)
            IDLE: begin
                if (found_c) begin
                    sel_n   = idx_c;
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                // Dwell expiry, early release and request drop share one exit path.
                if (cnt == '0 || Release || !Req[Sel]) begin
                    state_n = GAP;
                    last_n  = Sel;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Outputs are registered copies of the next-state decode.
        en_n   = (state_n == GRANT);
        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_rr_sel_encoder.sv
// Directed bench for rr_sel_encoder with HOLD_CYC=4.
module tb_rr_sel_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Req;
    logic       Release;
    logic [2:0] Sel;
    logic       En;
    logic       Busy;

    int n_tests = 0;
    int n_fail  = 0;

    rr_sel_encoder #(.HOLD_CYC(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .Req     (Req),
        .Release (Release),
        .Sel     (Sel),
        .En      (En),
        .Busy    (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full grant of len cycles on channel s, then the gap and the idle cycle.
    task automatic expect_grant(input string tag, input logic [2:0] s, input int len);
        for (int i = 0; i < len; i++) begin
            step();
            chk({tag, "_en"},   32'(En),   32'd1);
            chk({tag, "_sel"},  32'(Sel),  32'(s));
            chk({tag, "_busy"}, 32'(Busy), 32'd1);
        end
        step();
        chk({tag, "_gap_en"},   32'(En),   32'd0);
        chk({tag, "_gap_busy"}, 32'(Busy), 32'd1);
        step();
        chk({tag, "_idle_en"},   32'(En),   32'd0);
        chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; Req = 8'h00; Release = 1'b0;
        #1;
        chk("rst_sel",  32'(Sel),  32'd0);
        chk("rst_en",   32'(En),   32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single persistent requester: 4 high, 2 low, re-grant.
        Req = 8'h01;
        expect_grant("single", 3'd0, 4);
        step();
        chk("regrant_en",  32'(En),  32'd1);
        chk("regrant_sel", 32'(Sel), 32'd0);
        Req = 8'h00;
        step();
        chk("drop0_en", 32'(En), 32'd0);
        step();

        // Fresh reset so the full sweep starts at channel 0.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        Req = 8'hFF;
        for (int i = 0; i < 9; i++)
            expect_grant($sformatf("ff%0d", i), 3'(i % 8), 4);
        Req = 8'h00;

        // Wrap-around: after a grant to 6, channel 0 beats 6.
        Req = 8'h40;
        expect_grant("g6", 3'd6, 4);
        Req = 8'h41;
        step();
        chk("wrap_sel", 32'(Sel), 32'd0);
        chk("wrap_en",  32'(En),  32'd1);
        Req = 8'h00;
        step();
        step();

        // Early release in the second grant cycle.
        Req = 8'h08;
        step();
        chk("rel_c1_sel", 32'(Sel), 32'd3);
        chk("rel_c1_en",  32'(En),  32'd1);
        step();
        chk("rel_c2_en", 32'(En), 32'd1);
        Release = 1'b1;
        step();
        Release = 1'b0;
        chk("rel_gap_en",   32'(En),   32'd0);
        chk("rel_gap_busy", 32'(Busy), 32'd1);
        Req = 8'h00;
        step();
        chk("rel_idle_busy", 32'(Busy), 32'd0);

        // Request drop mid-grant; next search starts after channel 5.
        Req = 8'h20;
        step();
        chk("drop_sel", 32'(Sel), 32'd5);
        step();
        chk("drop_c2_en", 32'(En), 32'd1);
        Req = 8'h41;
        step();
        chk("drop_gap_en",   32'(En),   32'd0);
        chk("drop_gap_busy", 32'(Busy), 32'd1);
        step();
        chk("drop_idle_en", 32'(En), 32'd0);
        step();
        chk("after5_sel", 32'(Sel), 32'd6);
        chk("after5_en",  32'(En),  32'd1);
        Req = 8'h00;
        step();
        step();

        // Asynchronous reset mid-grant.
        Req = 8'h04;
        step();
        chk("pre_rst_sel", 32'(Sel), 32'd2);
        chk("pre_rst_en",  32'(En),  32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_en",   32'(En),   32'd0);
        chk("arst_sel",  32'(Sel),  32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        Req = 8'h80;
        step();
        chk("post_rst_sel", 32'(Sel), 32'd7);
        chk("post_rst_en",  32'(En),  32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_sel_encoder.md
Name: rr_sel_encoder

Overview:
- Upstream stage of the 3-to-8 enable decoder.
- Arbitrates 8 request lines round-robin and produces a registered 3-bit select index plus an enable strobe that drive the decoder's Din/En inputs.
- Each grant is held for a bounded dwell time or until released.
- A mandatory one-cycle enable-low gap separates consecutive grants, so the decoded one-hot output never switches directly between two channels.

Parameters:
- HOLD_CYC, 4, maximum grant length in cycles (legal 1..255).
- CNT_W, 8, dwell counter width; must hold HOLD_CYC-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Req  input  8  request vector; bit i requests channel i; level-sensitive.
- Release  input  1  early release of the current grant, from the consumer.
- Sel  output  3  granted channel index; registered; drives decoder Din.
- En  output  1  grant-valid strobe; registered; drives decoder En.
- Busy  output  1  high in GRANT and GAP states.

Behaviour:
- Reset (async, immediate):
  - Sel=3'b000, En=0, Busy=0.
  - State=IDLE, dwell counter=0.
  - Last-grant pointer Last=3'b111, so the first search starts at channel 0.
- Sampling and latency:
  - All outputs are registered. Inputs are sampled at the rising edge.
  - Req seen high in IDLE at edge k gives En=1 and Sel valid after edge k (1-cycle latency).
- State IDLE:
  - En=0, Busy=0. Sel holds its last value.
  - If Req!=0: pick the first set bit scanning Last+1, Last+2, ... mod 8 (wrap 7->0).
  - Load Sel with that index, load counter with HOLD_CYC-1, set En=1, go to GRANT.
  - If Req==0: stay in IDLE.
- State GRANT:
  - En=1, Busy=1. Sel stable for the whole grant.
  - Each cycle, exit to GAP if any of these holds: counter==0, Release==1, or Req[Sel]==0.
  - Otherwise the counter decrements.
  - On exit: En=0 at the same edge, Last<=Sel.
  - Grant length in cycles = min(HOLD_CYC, cycles until Release or Req drop).
  - HOLD_CYC=1 gives exactly one En-high cycle.
- State GAP:
  - En=0, Busy=1, exactly one cycle.
  - Then IDLE rules apply: arbitration occurs at the next edge.
  - Effective back-to-back pattern: En high HOLD_CYC cycles, low 2 cycles (GAP + IDLE arbitration edge).
- Round-robin fairness:
  - The channel just granted has lowest priority at the next arbitration.
  - A single persistent requester is re-granted after the gap.
- Simultaneous events:
  - Release and counter==0 together give a single exit; no double effect.
  - Changes to Req bits other than Sel during GRANT are ignored until the next arbitration.
- Reset mid-grant: En drops asynchronously to 0 and the pointer returns to 7.
- Release in IDLE or GAP is ignored.
- No X is ever driven on Sel or En.

Decomposition:
- Shared package holds:
  - state enum {IDLE, GRANT, GAP};
  - constant N_REQ=8;
  - constant IDX_W=3.
- Natural sub-module: rr_pick8, a combinational rotate-priority encoder. Inputs are Req[7:0] and Last[2:0]; outputs are a found flag and idx[2:0]. It is instantiated once.

Test Plan:
- Reset then Req=8'b0000_0001 held, HOLD_CYC=4:
  - Sel=0, En=1 from the first edge after Req for exactly 4 cycles.
  - Then En=0 for 2 cycles, then a re-grant of Sel=0.
- Req=8'hFF held:
  - Grants appear in order Sel=0,1,2,...,7,0, each 4 cycles long.
  - En is never high across a Sel change.
- Wrap-around, Last=6 after a grant to 6, Req=8'b0100_0001: next Sel=0, not 6.
- Grant to Sel=3, Release pulsed in the 2nd GRANT cycle: En falls after that edge (2 cycles high); Busy stays 1 for one more cycle.
- Grant to Sel=5, Req[5] dropped mid-grant: En=0 at the next edge, and the next arbitration starts from 6.
- rst asserted asynchronously mid-GRANT: En=0 and Sel=0 immediately, without a clock edge; after release, Req=8'h80 gives Sel=7.
